// File: rtl/enemy_spawner_if.sv
// Spawn handshake between the scheduler (master) and an enemy sprite unit (slave).
interface enemy_spawner_if #(
    parameter int unsigned X_POS_W = 10
) ();
    logic               spawn_valid;
    logic               spawn_ready;
    logic [X_POS_W-1:0] spawn_x;
    logic [1:0]         spawn_speed;

    modport master (
        output spawn_valid,
        output spawn_x,
        output spawn_speed,
        input  spawn_ready
    );

    modport slave (
        input  spawn_valid,
        input  spawn_x,
        input  spawn_speed,
        output spawn_ready
    );
endinterface

// File: rtl/enemy_spawner.sv
// Spawn scheduler: every CNT_MAX_TRIGGER enabled cycles, captures an LFSR value,
// folds it into the on-screen x range, picks a level-weighted speed and offers the
// result over a valid/ready handshake.
module enemy_spawner #(
    parameter int unsigned CNT_MAX_TRIGGER = 100,
    parameter int unsigned H_DISP          = 640,
    parameter int unsigned OBJ_X_SIZE      = 57,
    parameter int unsigned X_POS_W         = 10,
    parameter logic [15:0] SEED            = 16'hACE1
) (
    input  logic             clk_run,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [1:0]       level_i,
    enemy_spawner_if.master  spawn,
    output logic [7:0]       miss_cnt_o
);

    localparam int unsigned        CNT_W    = $clog2(CNT_MAX_TRIGGER);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CNT_MAX_TRIGGER - 1);
    localparam logic [X_POS_W-1:0] X_MAX    = X_POS_W'(H_DISP - OBJ_X_SIZE);
    localparam logic [X_POS_W-1:0] X_SPAN   = X_POS_W'(H_DISP - OBJ_X_SIZE + 1);
    localparam logic [15:0]        SEED_EFF = (SEED == 16'h0) ? 16'hACE1 : SEED;
    localparam logic [15:0]        TAPS     = 16'hB400;

    localparam logic [1:0] SPD_LOW    = 2'b01;
    localparam logic [1:0] SPD_MIDDLE = 2'b11;
    localparam logic [1:0] SPD_HIGH   = 2'b10;

    typedef enum logic [1:0] {StIdle, StCalc, StOffer} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [15:0]        lfsr_q;
    logic [1:0]         rnd_q;
    logic [X_POS_W-1:0] x_acc_q;
    logic [X_POS_W-1:0] x_q;
    logic [1:0]         speed_q;
    logic [7:0]         miss_q;

    logic        tick;
    logic        x_over;
    logic [15:0] lfsr_next;
    logic [1:0]  speed_sel;

    assign tick      = en_i && (cnt_q == CNT_LAST);
    assign x_over    = x_acc_q > X_MAX;
    assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0);

    // Level-weighted speed from the two top bits of the captured random value.
    always_comb begin
        speed_sel = SPD_LOW;
        unique case (level_i)
            2'd0: speed_sel = SPD_LOW;
            2'd1: speed_sel = (rnd_q == 2'b11) ? SPD_MIDDLE : SPD_LOW;
            2'd2: speed_sel = (rnd_q == 2'b11) ? SPD_HIGH :
                              (rnd_q == 2'b10) ? SPD_MIDDLE : SPD_LOW;
            2'd3: speed_sel = rnd_q[1] ? SPD_HIGH : SPD_MIDDLE;
        endcase
    end

    // Trigger counter: free-runs while enabled, frozen otherwise.
    always_ff @(posedge clk_run or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk_run or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (tick) state_d = StCalc;
            StCalc:  if (!x_over) state_d = StOffer;
            StOffer: if (spawn.spawn_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: valid is purely the OFFER state, so reset clears it at once.
    always_comb begin
        spawn.spawn_valid = (state_q == StOffer);
        spawn.spawn_x     = x_q;
        spawn.spawn_speed = speed_q;
        miss_cnt_o        = miss_q;
    end

    // Datapath: capture + LFSR step in IDLE, fold x into range in CALC.
    always_ff @(posedge clk_run or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q  <= SEED_EFF;
            rnd_q   <= '0;
            x_acc_q <= '0;
            x_q     <= '0;
            speed_q <= '0;
        end else begin
            if (state_q == StIdle && tick) begin
                rnd_q   <= lfsr_q[15:14];
                x_acc_q <= lfsr_q[X_POS_W-1:0];
                lfsr_q  <= lfsr_next;
            end else if (state_q == StCalc) begin
                if (x_over) begin
                    x_acc_q <= x_acc_q - X_SPAN;
                end else begin
                    x_q     <= x_acc_q;
                    speed_q <= speed_sel;
                end
            end
        end
    end

    // Ticks that arrive while a spawn is still in flight are counted, not queued.
    always_ff @(posedge clk_run or negedge rst_n) begin
        if (!rst_n) begin
            miss_q <= '0;
        end else if (tick && state_q != StIdle && miss_q != 8'hFF) begin
            miss_q <= miss_q + 8'd1;
        end
    end

endmodule
